// File: rtl/vlsu_vaddr_gen.sv
// VRF address generator for the VLSU: turns one register-access request into a
// stream of lane {set, off} addresses, one per beat, under valid/ready.
module vlsu_vaddr_gen #(
  parameter int unsigned NrVregs      = 16,
  parameter int unsigned NrAregs      = 16,
  parameter int unsigned NrBanks      = 4,
  parameter int unsigned NrSetPerVreg = 8,
  parameter int unsigned NrSetPerAreg = 16,
  localparam int unsigned AregBaseSet = NrVregs * NrSetPerVreg,
  localparam int unsigned NrVRFSets   = AregBaseSet + NrAregs * NrSetPerAreg,
  localparam int unsigned SetBits     = $clog2(NrVRFSets),
  localparam int unsigned OffBits     = $clog2(NrBanks),
  localparam int unsigned CapMax      = NrSetPerAreg * NrBanks,
  localparam int unsigned BeatBits    = $clog2(CapMax) + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_is_areg_i,
  input  logic [3:0]                 req_reg_i,
  input  logic [BeatBits-2:0]        req_start_i,
  input  logic [BeatBits-1:0]        req_nbeats_i,
  output logic                       addr_valid_o,
  input  logic                       addr_ready_i,
  output logic [SetBits+OffBits-1:0] addr_o,
  output logic                       addr_last_o,
  output logic                       err_o,
  output logic                       idle_o
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q, state_d;
  logic [SetBits-1:0]   set_q, set_d;
  logic [OffBits-1:0]   off_q, off_d;
  logic [BeatBits-1:0]  rem_q, rem_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;
  logic                 idle_q, idle_d;

  logic [31:0] reg_w, start_w, nbeats_w, cap_w, base_w, avail_w, n_eff;
  logic        reg_bad, start_over, req_illegal;
  logic        req_hs, addr_hs;

  // Request decode is done in 32-bit unsigned arithmetic so no sum can wrap.
  assign reg_w    = 32'(req_reg_i);
  assign start_w  = 32'(req_start_i);
  assign nbeats_w = 32'(req_nbeats_i);
  assign cap_w    = req_is_areg_i ? 32'(NrSetPerAreg * NrBanks) : 32'(NrSetPerVreg * NrBanks);
  assign base_w   = req_is_areg_i ? 32'(AregBaseSet) + reg_w * 32'(NrSetPerAreg)
                                  : reg_w * 32'(NrSetPerVreg);
  assign reg_bad    = req_is_areg_i ? (reg_w >= 32'(NrAregs)) : (reg_w >= 32'(NrVregs));
  assign start_over = start_w >= cap_w;
  assign avail_w    = cap_w - start_w;
  assign n_eff      = (reg_bad || start_over) ? 32'd0
                    : ((nbeats_w < avail_w) ? nbeats_w : avail_w);
  assign req_illegal = (nbeats_w == 32'd0) || start_over
                    || ((start_w + nbeats_w) > cap_w) || reg_bad;

  assign addr_hs     = valid_q && addr_ready_i;
  assign req_ready_o = (state_q == IDLE) || ((state_q == RUN) && addr_ready_i && last_q);
  assign req_hs      = req_valid_i && req_ready_o;

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    off_d   = off_q;
    rem_d   = rem_q;
    last_d  = last_q;
    err_d   = 1'b0;
    if (addr_hs) begin
      rem_d  = rem_q - 1'b1;
      last_d = (rem_q == BeatBits'(2));
      // The address is left on the final beat so set never steps past the register.
      if (last_q) begin
        state_d = IDLE;
      end else if (off_q == OffBits'(NrBanks - 1)) begin
        off_d = '0;
        set_d = set_q + 1'b1;
      end else begin
        off_d = off_q + 1'b1;
      end
    end
    if (req_hs) begin
      err_d = req_illegal;
      if (n_eff != 32'd0) begin
        state_d = RUN;
        set_d   = SetBits'(base_w + (start_w >> OffBits));
        off_d   = req_start_i[OffBits-1:0];
        rem_d   = BeatBits'(n_eff);
        last_d  = (n_eff == 32'd1);
      end else begin
        state_d = IDLE;
      end
    end
    valid_d = (state_d == RUN);
    idle_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      set_q   <= '0;
      off_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      off_q   <= off_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
      idle_q  <= idle_d;
    end
  end

  assign addr_valid_o = valid_q;
  assign addr_o       = {set_q, off_q};
  assign addr_last_o  = last_q;
  assign err_o        = err_q;
  assign idle_o       = idle_q;

endmodule

// File: tb/tb_vlsu_vaddr_gen.sv
// Bench for vlsu_vaddr_gen: directed and random requests compared each cycle
// against a queue of expected addresses built from the register layout.
module tb_vlsu_vaddr_gen;
  localparam int NrVregs = 16, NrAregs = 16, NrBanks = 4;
  localparam int NrSetPerVreg = 8, NrSetPerAreg = 16;
  localparam int SetBits = 9, OffBits = 2, BeatBits = 7;

  logic clk_i = 1'b0, rst_i;
  logic req_valid_i, req_ready_o, req_is_areg_i;
  logic [3:0] req_reg_i;
  logic [BeatBits-2:0] req_start_i;
  logic [BeatBits-1:0] req_nbeats_i;
  logic addr_valid_o, addr_ready_i, addr_last_o, err_o, idle_o;
  logic [SetBits+OffBits-1:0] addr_o;

  vlsu_vaddr_gen dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_is_areg_i(req_is_areg_i), .req_reg_i(req_reg_i),
    .req_start_i(req_start_i), .req_nbeats_i(req_nbeats_i),
    .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i),
    .addr_o(addr_o), .addr_last_o(addr_last_o),
    .err_o(err_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit is_areg;
    int rg;
    int start;
    int nb;
  } req_t;

  req_t pend[$];
  int   exp_addr[$];
  bit   exp_last[$];
  bit   err_exp;
  bit   prev_stall;
  int   prev_addr;
  int   popped;
  int   rdy_pct;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected beats: word w of the register lives at set base + w/NrBanks, bank w%NrBanks.
  task automatic model_accept(input req_t r);
    int cap, nregs, base, n, w;
    bit bad;
    cap   = r.is_areg ? NrSetPerAreg * NrBanks : NrSetPerVreg * NrBanks;
    nregs = r.is_areg ? NrAregs : NrVregs;
    base  = r.is_areg ? NrVregs * NrSetPerVreg + r.rg * NrSetPerAreg : r.rg * NrSetPerVreg;
    bad   = r.rg >= nregs;
    err_exp = (r.nb == 0) || (r.start >= cap) || (r.start + r.nb > cap) || bad;
    if (bad || r.start >= cap) n = 0;
    else n = (r.nb < cap - r.start) ? r.nb : cap - r.start;
    for (int k = 0; k < n; k++) begin
      w = r.start + k;
      exp_addr.push_back((base + w / NrBanks) * (1 << OffBits) + w % NrBanks);
      exp_last.push_back(k == n - 1);
    end
  endtask

  task automatic cycle();
    bit rexp, hs, busy;
    req_t r;
    if (pend.size() != 0) begin
      req_valid_i   = 1'b1;
      req_is_areg_i = pend[0].is_areg;
      req_reg_i     = 4'(pend[0].rg);
      req_start_i   = 6'(pend[0].start);
      req_nbeats_i  = 7'(pend[0].nb);
    end else begin
      req_valid_i  = 1'b0;
      req_reg_i    = 4'($urandom);
      req_start_i  = 6'($urandom);
      req_nbeats_i = 7'($urandom);
    end
    addr_ready_i = ($urandom_range(0, 99) < rdy_pct);
    #1;
    busy = exp_addr.size() != 0;
    chk("addr_valid", addr_valid_o, busy);
    chk("idle", idle_o, !busy);
    chk("err", err_o, err_exp);
    if (busy) begin
      chk("addr", addr_o, exp_addr[0]);
      chk("last", addr_last_o, exp_last[0]);
    end
    if (prev_stall) chk("stall_hold", addr_o, prev_addr);
    rexp = !busy || (addr_ready_i && exp_last[0]);
    chk("req_ready", req_ready_o, rexp);
    hs = busy && addr_ready_i;
    prev_stall = busy && !addr_ready_i;
    if (busy) prev_addr = exp_addr[0];
    if (hs) begin
      void'(exp_addr.pop_front());
      void'(exp_last.pop_front());
      popped++;
    end
    err_exp = 1'b0;
    if (req_valid_i && rexp) begin
      r = pend.pop_front();
      model_accept(r);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int budget = 600;
    while ((pend.size() != 0 || exp_addr.size() != 0 || err_exp) && budget > 0) begin
      cycle();
      budget--;
    end
    chk("drain_timeout", 32'(pend.size() + exp_addr.size()), 0);
    repeat (2) cycle();
  endtask

  task automatic push_req(input bit a, input int rg, input int st, input int nb);
    req_t r;
    r.is_areg = a; r.rg = rg; r.start = st; r.nb = nb;
    pend.push_back(r);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    #2;
    chk("rst_valid", addr_valid_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_last", addr_last_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_ready", req_ready_o, 1);
    pend.delete();
    exp_addr.delete();
    exp_last.delete();
    err_exp = 1'b0;
    prev_stall = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    int budget;
    req_is_areg_i = 1'b0;
    addr_ready_i = 1'b1;
    rdy_pct = 100;
    popped = 0;
    do_reset();

    push_req(0, 3, 0, 5);     // (24,0)..(25,0)
    drain();
    push_req(1, 2, 6, 3);     // (161,2)(161,3)(162,0)
    drain();
    push_req(0, 15, 30, 4);   // truncated to (127,2)(127,3) with err
    drain();
    push_req(0, 5, 0, 0);     // zero beats: err only
    drain();
    push_req(1, 15, 60, 4);   // top of the VRF, set 383
    drain();

    rdy_pct = 50;
    push_req(0, 7, 1, 9);
    push_req(1, 4, 3, 6);
    drain();

    rdy_pct = 100;
    push_req(0, 1, 0, 8);
    popped = 0;
    budget = 20;
    while (popped < 2 && budget > 0) begin
      cycle();
      budget--;
    end
    chk("pre_reset_beats", popped, 2);
    do_reset();
    repeat (4) cycle();

    for (int i = 0; i < 60; i++) begin
      int a, cap, st, nb;
      a   = $urandom_range(0, 1);
      cap = a ? NrSetPerAreg * NrBanks : NrSetPerVreg * NrBanks;
      st  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, cap - 1);
      nb  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 127) : $urandom_range(1, cap - st + 1);
      push_req(a[0], $urandom_range(0, 15), st, nb);
      if ($urandom_range(0, 2) == 0) begin
        rdy_pct = $urandom_range(0, 2) == 0 ? 100 : 60;
        drain();
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
